mul_reg: RTL and testbench

MUL_REG -- requirements
Module: mul_reg

---
 rtl/mul_reg_pkg.sv | 19 +
 rtl/mul_reg.sv | 50 +++++
 tb/tb_mul_reg.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mul_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_reg_pkg
// Description : Shared CPU constants for the ALU, multiplier and product
//               register. A CPU word is 24 bits and a full product is two
//               words wide.
// Revision    : 1.0  initial release
// ============================================================================
package mul_reg_pkg;

    // Width of one CPU data word.
    localparam int CPU_WORD_WIDTH = 24;

    // Full multiplier product width (WIDTH) and its half-word split (HALF).
    localparam int MUL_WIDTH = 2 * CPU_WORD_WIDTH;
    localparam int MUL_HALF  = MUL_WIDTH / 2;

endpackage : mul_reg_pkg
`default_nettype wire

// File: rtl/mul_reg.sv
`default_nettype none
// ============================================================================
// Module      : mul_reg
// Description : Product register. Captures the multiplier product on every
//               rising clock edge and presents it whole, split into upper and
//               lower CPU words, and as zero / negative status flags. All
//               outputs derive only from the stored value, so changes on
//               WriteData between edges are invisible.
// Revision    : 1.0  initial release
// ============================================================================
module mul_reg
    import mul_reg_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH-1:0]   WriteData,
    input  logic               Clock,
    output logic [WIDTH-1:0]   ReadData,
    input  logic               Reset,
    output logic [WIDTH/2-1:0] ReadHi,
    output logic [WIDTH/2-1:0] ReadLo,
    output logic               Zero,
    output logic               Negative
);

    localparam int HALF = WIDTH / 2;

    // Stored product; no power-up value until the first reset or write.
    logic [WIDTH-1:0] r_product;

    // Load the product every edge; a synchronous reset wins over the write.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_product <= '0;
        end else begin
            r_product <= WriteData;
        end
    end

    // Read views are pure slices of the register, no extension applied.
    assign ReadData = r_product;
    assign ReadHi   = r_product[WIDTH-1:HALF];
    assign ReadLo   = r_product[HALF-1:0];

    // Status flags treat the product as a two's complement number.
    assign Zero     = ~|r_product;
    assign Negative = r_product[WIDTH-1];

endmodule : mul_reg
`default_nettype wire

// File: tb/tb_mul_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_reg
// Description : Scoreboard bench for mul_reg. The driver pushes the product
//               expected after each edge; a monitor pops it after the edge and
//               derives every output arithmetically from it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mul_reg;

    localparam int  W    = 48;
    localparam int  H    = 24;
    localparam longint unsigned TWO_H   = 64'd1 << H;
    localparam longint unsigned SIGN_TH = 64'd1 << (W - 1);

    logic [W-1:0] WriteData = '0;
    logic         Clock     = 1'b0;
    logic [W-1:0] ReadData;
    logic         Reset     = 1'b0;
    logic [H-1:0] ReadHi;
    logic [H-1:0] ReadLo;
    logic         Zero;
    logic         Negative;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur;
    bit           cur_valid = 1'b0;

    mul_reg dut (
        .WriteData (WriteData),
        .Clock     (Clock),
        .ReadData  (ReadData),
        .Reset     (Reset),
        .ReadHi    (ReadHi),
        .ReadLo    (ReadLo),
        .Zero      (Zero),
        .Negative  (Negative)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: outputs expressed with plain arithmetic on the stored value.
    task automatic check_all(input string tag, input logic [W-1:0] p);
        longint unsigned v;
        v = 64'(p);
        check({tag, "_data"}, 64'(ReadData), v);
        check({tag, "_hi"},   64'(ReadHi),   v / TWO_H);
        check({tag, "_lo"},   64'(ReadLo),   v % TWO_H);
        check({tag, "_zero"}, 64'(Zero),     (v == 0) ? 64'd1 : 64'd0);
        check({tag, "_neg"},  64'(Negative), (v >= SIGN_TH) ? 64'd1 : 64'd0);
    endtask

    // Monitor: after each edge compare against the next scoreboard entry.
    initial begin
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                cur       = exp_q.pop_front();
                cur_valid = 1'b1;
                check_all("edge", cur);
            end
        end
    end

    // Monitor: mid-cycle the outputs must still show the last stored value.
    initial begin
        forever begin
            @(negedge Clock);
            if (cur_valid) begin
                check_all("hold", cur);
            end
        end
    end

    // One edge of stimulus; the expected product follows the reset rule.
    task automatic step(input logic rst, input logic [W-1:0] d);
        @(posedge Clock);
        #2;
        Reset     = rst;
        WriteData = d;
        exp_q.push_back(rst ? '0 : d);
    endtask

    initial begin
        logic [W-1:0] rnd;
        int           waited;

        // Directed scenarios.
        step(1'b0, 48'd5);
        step(1'b1, 48'h123456789ABC);
        step(1'b0, 48'h123456789ABC);
        step(1'b0, 48'hFFFFFFFFFFFF);

        // WriteData toggles inside one cycle; only the last value is stored.
        @(posedge Clock);
        #2;
        Reset     = 1'b0;
        WriteData = 48'd7;
        #2;
        WriteData = 48'd9;
        #2;
        WriteData = 48'd11;
        exp_q.push_back(48'd11);

        step(1'b0, 48'd1);
        step(1'b0, 48'd2);
        step(1'b0, 48'd3);
        step(1'b0, 48'h800000000000);
        step(1'b0, 48'd0);
        step(1'b1, 48'hFFFFFFFFFFFF);

        // Randomized traffic with occasional resets and sparse patterns.
        for (int i = 0; i < 200; i++) begin
            rnd = {16'($urandom), 32'($urandom)};
            case ($urandom_range(0, 5))
                0:       rnd = '0;
                1:       rnd = rnd & 48'h00000000FFFF;
                2:       rnd = rnd | 48'h800000000000;
                default: ;
            endcase
            step(($urandom_range(0, 7) == 0), rnd);
        end

        // Let the scoreboard drain, bounded.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge Clock);
            waited++;
        end
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mul_reg
`default_nettype wire
